// File: rtl/bcd2b_if.sv
// Handshake bundle between a BCD producer and the sequential BCD-to-binary converter.
// Valid/ready: a word transfers on a rising edge where in_valid and in_ready are both 1.
interface bcd2b_if #(
  parameter int DIGIT = 2,
  parameter int WIDTH = 7
);
  logic                 in_valid;
  logic [4*DIGIT-1:0]   BCD_code;
  logic                 in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     Binary_code;
  logic                 err_digit;
  logic                 ovf;

  modport master (
    output in_valid, BCD_code,
    input  in_ready, out_valid, Binary_code, err_digit, ovf
  );

  modport slave (
    input  in_valid, BCD_code,
    output in_ready, out_valid, Binary_code, err_digit, ovf
  );
endinterface

// File: rtl/bcd2b_seq.sv
// Sequential BCD-to-binary converter using one reverse double-dabble step per cycle.
// Results are held for a single OUT cycle; a new word may be accepted in that same cycle.
module bcd2b_seq #(
  parameter int DIGIT = 2,
  parameter int WIDTH = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  bcd2b_if.slave      bus,
  output logic [1:0]  state_dbg
);
  localparam int BW = 4 * DIGIT;
  localparam int TW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    work;
  logic [TW-1:0]    step_val;
  logic             err_r;
  logic             err_in;

  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] bin_r;
  logic             err_o_r;
  logic             ovf_r;

  // Shift right, then pull each BCD field back into range (>=8 minus 3).
  always_comb begin
    step_val = work >> 1;
    for (int i = 0; i < DIGIT; i++) begin
      if (step_val[WIDTH+4*i +: 4] >= 4'd8)
        step_val[WIDTH+4*i +: 4] = step_val[WIDTH+4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      err_in = err_in | (bus.BCD_code[4*i +: 4] > 4'd9);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      work        <= '0;
      err_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      bin_r       <= '0;
      err_o_r     <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      bin_r       <= '0;
      err_o_r     <= 1'b0;
      ovf_r       <= 1'b0;
      case (state)
        IDLE, OUT: begin
          if (bus.in_valid) begin
            work       <= {bus.BCD_code, {WIDTH{1'b0}}};
            cnt        <= '0;
            err_r      <= err_in;
            state      <= CONV;
            in_ready_r <= 1'b0;
          end else begin
            state      <= IDLE;
            in_ready_r <= 1'b1;
          end
        end
        CONV: begin
          work <= step_val;
          cnt  <= cnt + 1'b1;
          // Final step: results come from step_val so they line up with the OUT cycle.
          if (cnt == CW'(WIDTH - 1)) begin
            state       <= OUT;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b1;
            if (err_r) begin
              err_o_r <= 1'b1;
            end else if (|step_val[TW-1:WIDTH]) begin
              ovf_r <= 1'b1;
              bin_r <= '1;
            end else begin
              bin_r <= step_val[WIDTH-1:0];
            end
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.Binary_code = bin_r;
  assign bus.err_digit   = err_o_r;
  assign bus.ovf         = ovf_r;
  assign state_dbg       = state;

endmodule

// File: tb/tb_bcd2b_seq.sv
// Directed bench for bcd2b_seq: default instance (WIDTH=7) and a WIDTH=6 instance for saturation.
module tb_bcd2b_seq;
  logic       clk;
  logic       rst_n;
  logic [1:0] st0;
  logic [1:0] st1;
  int         n_checks;
  int         n_pass;

  bcd2b_if #(.DIGIT(2), .WIDTH(7)) if0 ();
  bcd2b_if #(.DIGIT(2), .WIDTH(6)) if1 ();

  bcd2b_seq #(.DIGIT(2), .WIDTH(7)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .state_dbg(st0)
  );
  bcd2b_seq #(.DIGIT(2), .WIDTH(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .state_dbg(st1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic drive(input int sel, input logic v, input logic [7:0] code);
    if (sel == 0) begin
      if0.in_valid = v;
      if0.BCD_code = code;
    end else begin
      if1.in_valid = v;
      if1.BCD_code = code;
    end
  endtask

  task automatic sample(input int sel, output logic ov, output logic [31:0] bin,
                        output logic er, output logic of, output logic rdy);
    if (sel == 0) begin
      ov = if0.out_valid; bin = 32'(if0.Binary_code); er = if0.err_digit;
      of = if0.ovf; rdy = if0.in_ready;
    end else begin
      ov = if1.out_valid; bin = 32'(if1.Binary_code); er = if1.err_digit;
      of = if1.ovf; rdy = if1.in_ready;
    end
  endtask

  // Presents one word, waits (bounded) for the strobe, checks latency, result and pulse width.
  task automatic convert(input string tag, input int sel, input logic [7:0] code,
                         input int exp_bin, input logic exp_err, input logic exp_ovf);
    logic        ov, er, of, rdy;
    logic [31:0] bin;
    int          w;
    int          lat;
    w   = (sel == 0) ? 7 : 6;
    lat = 0;
    @(negedge clk);
    sample(sel, ov, bin, er, of, rdy);
    check({tag, "_rdy"}, 32'(rdy), 32'd1);
    drive(sel, 1'b1, code);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      drive(sel, 1'b0, 8'h00);
      sample(sel, ov, bin, er, of, rdy);
      if (ov) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(w + 1));
    check({tag, "_bin"}, bin, 32'(exp_bin));
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    check({tag, "_ovf"}, 32'(of), 32'(exp_ovf));
    @(negedge clk);
    sample(sel, ov, bin, er, of, rdy);
    check({tag, "_pulse"}, 32'(ov), 32'd0);
    check({tag, "_idlebin"}, bin, 32'd0);
  endtask

  initial begin
    logic        ov, er, of, rdy;
    logic [31:0] bin;
    int          early;

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (2) @(negedge clk);

    // reset state
    sample(0, ov, bin, er, of, rdy);
    check("rst_out_valid", 32'(ov), 32'd0);
    check("rst_in_ready", 32'(rdy), 32'd1);
    check("rst_bin", bin, 32'd0);
    check("rst_err", 32'(er), 32'd0);
    check("rst_ovf", 32'(of), 32'd0);
    check("rst_state", 32'(st0), 32'd0);
    rst_n = 1'b1;

    convert("c42", 0, 8'h42, 42, 1'b0, 1'b0);
    convert("c99", 0, 8'h99, 99, 1'b0, 1'b0);
    convert("c00", 0, 8'h00, 0, 1'b0, 1'b0);
    convert("c3a", 0, 8'h3A, 0, 1'b1, 1'b0);
    convert("ca0", 0, 8'hA0, 0, 1'b1, 1'b0);
    convert("c01", 0, 8'h01, 1, 1'b0, 1'b0);
    convert("w6_63", 1, 8'h63, 63, 1'b0, 1'b0);
    convert("w6_64", 1, 8'h64, 63, 1'b0, 1'b1);
    convert("w6_99", 1, 8'h99, 63, 1'b0, 1'b1);
    convert("w6_9a", 1, 8'h9A, 0, 1'b1, 1'b0);

    // back-to-back: in_valid held during CONV, second word offered in the OUT cycle
    @(negedge clk);
    drive(0, 1'b1, 8'h12);
    early = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      sample(0, ov, bin, er, of, rdy);
      if (ov) early++;
    end
    check("b2b_early1", 32'(early), 32'd0);
    @(negedge clk);
    sample(0, ov, bin, er, of, rdy);
    check("b2b_ov1", 32'(ov), 32'd1);
    check("b2b_bin1", bin, 32'd12);
    check("b2b_rdy_out", 32'(rdy), 32'd1);
    drive(0, 1'b1, 8'h34);
    early = 0;
    for (int i = 9; i <= 15; i++) begin
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      sample(0, ov, bin, er, of, rdy);
      if (ov) early++;
    end
    check("b2b_early2", 32'(early), 32'd0);
    @(negedge clk);
    sample(0, ov, bin, er, of, rdy);
    check("b2b_ov2", 32'(ov), 32'd1);
    check("b2b_bin2", bin, 32'd34);
    @(negedge clk);
    sample(0, ov, bin, er, of, rdy);
    check("b2b_end", 32'(ov), 32'd0);
    check("b2b_idle", 32'(st0), 32'd0);

    // reset mid-conversion
    @(negedge clk);
    drive(0, 1'b1, 8'h57);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    check("mid_state_conv", 32'(st0), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b1, 8'h99);
    #1;
    sample(0, ov, bin, er, of, rdy);
    check("mid_rst_state", 32'(st0), 32'd0);
    check("mid_rst_rdy", 32'(rdy), 32'd1);
    check("mid_rst_ov", 32'(ov), 32'd0);
    check("mid_rst_bin", bin, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_ignore", 32'(st0), 32'd0);
    rst_n = 1'b1;
    drive(0, 1'b0, 8'h00);
    early = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sample(0, ov, bin, er, of, rdy);
      if (ov) early++;
    end
    check("mid_no_pulse", 32'(early), 32'd0);
    convert("c57", 0, 8'h57, 57, 1'b0, 1'b0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bcd2b_seq.md
BCD2B_SEQ -- requirements
Module: bcd2b_seq

Interface
REQ-001 The module SHALL have parameter DIGIT, default 2, giving the number of BCD input digits.
REQ-002 The module SHALL have parameter WIDTH, default 7, giving the binary output width; WIDTH >= 4 is legal.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: BCD_code is valid this cycle.
REQ-006 The module SHALL have port BCD_code, input, 4*DIGIT bits: packed digits {..., hundreds, tens, ones}, ones digit in [3:0].
REQ-007 The module SHALL have port in_ready, output, 1 bit: high when a new in_valid will be accepted.
REQ-008 The module SHALL have port out_valid, output, 1 bit: one-cycle result strobe.
REQ-009 The module SHALL have port Binary_code, output, WIDTH bits: the converted value.
REQ-010 The module SHALL have port err_digit, output, 1 bit: some input digit was greater than 9.
REQ-011 The module SHALL have port ovf, output, 1 bit: the decimal value is at least 2^WIDTH.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CONV and OUT.
REQ-013 IDLE -> CONV on an edge with in_valid=1; the working register loads {BCD_code, WIDTH'b0}, the iteration counter clears, and err_digit_r is latched as OR over digits of (digit > 9).
REQ-014 in_ready SHALL be 1 in IDLE and in OUT, and 0 in CONV; in_valid while in_ready=0 is ignored, with no effect on state or data.
REQ-015 Each CONV cycle SHALL perform one reverse double-dabble step on the (4*DIGIT+WIDTH)-bit register:
- logical shift right by 1;
- then, for every 4-bit BCD digit field, subtract 3 if the field value is >= 8;
- both operations in the same cycle.
REQ-016 CONV SHALL last exactly WIDTH cycles (counter 0..WIDTH-1), then go to OUT.
REQ-017 OUT SHALL last exactly one cycle: go to CONV if in_valid=1 that edge (back-to-back accept, same load as REQ-013), otherwise to IDLE.
REQ-018 Latency: if in_valid is sampled at edge k, out_valid SHALL be 1 in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after acceptance, and 0 otherwise.
REQ-019 In OUT, Binary_code SHALL equal the low WIDTH bits of the working register.
REQ-020 ovf SHALL be 1 when the upper 4*DIGIT residue bits are nonzero after the final step.
REQ-021 If err_digit_r=1, Binary_code SHALL be 0 and ovf SHALL be 0 in OUT, with err_digit=1.
REQ-022 If ovf=1, Binary_code SHALL be forced to all ones (saturate).
REQ-023 When out_valid=0, Binary_code, err_digit and ovf SHALL all be 0.
REQ-024 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.
REQ-025 The digit correction SHALL be a >=8 compare with a 4-bit subtract; no divider and no multiplier are permitted.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, counter 0 and working register 0.
REQ-027 Reset SHALL force outputs to in_ready=1, out_valid=0, Binary_code=0, err_digit=0 and ovf=0.
REQ-028 Reset asserted during CONV or OUT SHALL abort the conversion with no out_valid pulse afterwards.
REQ-029 in_valid SHALL be ignored while rst_n=0 and on the first edge after release is accepted normally.

Verification
REQ-030 Defaults, in_valid with BCD_code=8'h42 -> out_valid exactly 8 cycles later, Binary_code=42, err_digit=0, ovf=0, single-cycle pulse.
REQ-031 Defaults, BCD_code=8'h99 then 8'h00 -> results 99 then 0; zero input still yields out_valid after 8 cycles.
REQ-032 Defaults, BCD_code=8'h3A -> out_valid after 8 cycles with err_digit=1, Binary_code=0, ovf=0.
REQ-033 DIGIT=2, WIDTH=6:
- BCD_code=8'h63 -> Binary_code=63, ovf=0;
- BCD_code=8'h64 -> Binary_code=6'h3F, ovf=1.
REQ-034 Back-to-back, defaults: in_valid held high with 8'h12 then 8'h34, the second presented in the OUT cycle of the first -> pulses for 12 and 34 exactly 8 cycles apart; in_valid during CONV has no effect.
REQ-035 Reset mid-operation: rst_n pulsed low 3 cycles after accepting 8'h57 -> outputs zero at once, no out_valid for 20 cycles, then a new 8'h57 converts to 57.
